sextium_core_p: RTL and testbench

- Parametrised, handshaked successor of the Sextium III core: same accumulator machine (ACC, AR, DR, IR, IP) and 4-bit opcode ISA, packed WIDTH/4 opcodes per instruction word.
- Generalised to any WIDTH that is a multiple of 4 (>=8).
- Uses split unidirectional buses with ready handshakes, so memory and I/O may insert wait states.
- Adds a HALT state and an explicit one-hot state machine in place of the separate controller.

---
 rtl/sextium_core_p.sv | 243 ++++++++++++++++++++++++
 tb/tb_sextium_core_p.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sextium_core_p.sv
`default_nettype none
// ============================================================================
// Module      : sextium_core_p
// Description : Parametrised accumulator core with packed 4-bit opcodes and
//               ready-handshaked memory/IO buses.
// Revision    : 1.0 - initial release
// ============================================================================
module sextium_core_p #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_IP = '0
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] io_rdata,
    output logic [WIDTH-1:0] io_wdata,
    output logic             io_read,
    output logic             io_write,
    input  logic             io_ready,
    output logic             halted,
    output logic [WIDTH-1:0] dbg_ip
);

    localparam int unsigned      SLOTS       = WIDTH / 4;
    localparam int unsigned      SW          = $clog2(SLOTS);
    localparam logic [SW-1:0]    C_LAST_SLOT = SW'(SLOTS - 1);
    localparam logic [WIDTH-1:0] C_WIDTH     = WIDTH'(WIDTH);

    localparam logic [3:0] C_OP_SYSCALL = 4'h1;
    localparam logic [3:0] C_OP_LOAD    = 4'h2;
    localparam logic [3:0] C_OP_STORE   = 4'h3;
    localparam logic [3:0] C_OP_SWAPA   = 4'h4;
    localparam logic [3:0] C_OP_SWAPD   = 4'h5;
    localparam logic [3:0] C_OP_BRANCHZ = 4'h6;
    localparam logic [3:0] C_OP_BRANCHN = 4'h7;
    localparam logic [3:0] C_OP_JUMP    = 4'h8;
    localparam logic [3:0] C_OP_CONST   = 4'h9;
    localparam logic [3:0] C_OP_ADD     = 4'hA;
    localparam logic [3:0] C_OP_SUB     = 4'hB;
    localparam logic [3:0] C_OP_MUL     = 4'hC;
    localparam logic [3:0] C_OP_DIV     = 4'hD;
    localparam logic [3:0] C_OP_SHIFT   = 4'hE;
    localparam logic [3:0] C_OP_NAND    = 4'hF;

    typedef enum logic [4:0] {
        S_FETCH = 5'b00001,
        S_EXEC  = 5'b00010,
        S_MEM   = 5'b00100,
        S_IO    = 5'b01000,
        S_HALT  = 5'b10000
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_ar;
    logic [WIDTH-1:0] r_dr;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_ip;
    logic [SW-1:0]    r_slot;
    logic [WIDTH-1:0] r_maddr;
    logic             r_mem_wr;
    logic             r_const;
    logic             r_io_wr;
    logic             r_active;

    logic [3:0]       w_op;
    logic             w_last;
    logic [SW-1:0]    w_next_slot;
    state_t           w_next_state;
    logic             w_dr_neg;
    logic [WIDTH-1:0] w_shamt;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_alu;

    // Most significant nibble executes first.
    always_comb begin
        w_op = r_ir[WIDTH-1 -: 4];
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (r_slot == SW'(i)) begin
                w_op = r_ir[4*(int'(SLOTS)-1-i) +: 4];
            end
        end
    end

    assign w_last       = (r_slot == C_LAST_SLOT);
    assign w_next_slot  = w_last ? '0 : r_slot + 1'b1;
    assign w_next_state = w_last ? S_FETCH : S_EXEC;

    // DR is a signed shift distance; the most negative value falls into the >=WIDTH case.
    assign w_dr_neg = r_dr[WIDTH-1];
    assign w_shamt  = w_dr_neg ? (~r_dr + 1'b1) : r_dr;
    assign w_shift  = (w_shamt >= C_WIDTH) ? '0 :
                      (w_dr_neg ? (r_acc >> w_shamt) : (r_acc << w_shamt));
    assign w_div    = (r_dr == '0) ? '1 : (r_acc / r_dr);

    always_comb begin
        w_alu = r_acc;
        case (w_op)
            C_OP_ADD:   w_alu = r_acc + r_dr;
            C_OP_SUB:   w_alu = r_acc - r_dr;
            C_OP_MUL:   w_alu = r_acc * r_dr;
            C_OP_DIV:   w_alu = w_div;
            C_OP_SHIFT: w_alu = w_shift;
            C_OP_NAND:  w_alu = ~(r_acc & r_dr);
            default:    w_alu = r_acc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_acc    <= '0;
            r_ar     <= '0;
            r_dr     <= '0;
            r_ir     <= '0;
            r_ip     <= RESET_IP;
            r_slot   <= '0;
            r_maddr  <= '0;
            r_mem_wr <= 1'b0;
            r_const  <= 1'b0;
            r_io_wr  <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_active && mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_ip    <= r_ip + 1'b1;
                        r_slot  <= '0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_op)
                        C_OP_SYSCALL: begin
                            if (r_acc == '0) begin
                                r_state <= S_HALT;
                            end else if (r_acc == WIDTH'(1)) begin
                                r_io_wr <= 1'b0;
                                r_state <= S_IO;
                            end else if (r_acc == WIDTH'(2)) begin
                                r_io_wr <= 1'b1;
                                r_state <= S_IO;
                            end else begin
                                r_slot  <= w_next_slot;
                                r_state <= w_next_state;
                            end
                        end
                        C_OP_LOAD, C_OP_STORE: begin
                            r_maddr  <= r_ar;
                            r_mem_wr <= (w_op == C_OP_STORE);
                            r_const  <= 1'b0;
                            r_state  <= S_MEM;
                        end
                        C_OP_CONST: begin
                            r_maddr  <= r_ip;
                            r_mem_wr <= 1'b0;
                            r_const  <= 1'b1;
                            r_state  <= S_MEM;
                        end
                        C_OP_SWAPA: begin
                            r_acc   <= r_ar;
                            r_ar    <= r_acc;
                            r_slot  <= w_next_slot;
                            r_state <= w_next_state;
                        end
                        C_OP_SWAPD: begin
                            r_acc   <= r_dr;
                            r_dr    <= r_acc;
                            r_slot  <= w_next_slot;
                            r_state <= w_next_state;
                        end
                        C_OP_BRANCHZ, C_OP_BRANCHN: begin
                            if ((w_op == C_OP_BRANCHZ) ? (r_acc == '0) : r_acc[WIDTH-1]) begin
                                r_ip    <= r_ar;
                                r_state <= S_FETCH;
                            end else begin
                                r_slot  <= w_next_slot;
                                r_state <= w_next_state;
                            end
                        end
                        C_OP_JUMP: begin
                            r_ip    <= r_acc;
                            r_state <= S_FETCH;
                        end
                        default: begin
                            r_acc   <= w_alu;
                            r_slot  <= w_next_slot;
                            r_state <= w_next_state;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (!r_mem_wr) begin
                            r_acc <= mem_rdata;
                        end
                        if (r_const) begin
                            r_ip <= r_ip + 1'b1;
                        end
                        r_slot  <= w_next_slot;
                        r_state <= w_next_state;
                    end
                end
                S_IO: begin
                    if (io_ready) begin
                        if (!r_io_wr) begin
                            r_acc <= io_rdata;
                        end
                        r_slot  <= w_next_slot;
                        r_state <= w_next_state;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode from registered state only, never from the ready inputs.
    assign mem_read  = r_active & ((r_state == S_FETCH) | ((r_state == S_MEM) & ~r_mem_wr));
    assign mem_write = r_active & (r_state == S_MEM) & r_mem_wr;
    assign io_read   = r_active & (r_state == S_IO) & ~r_io_wr;
    assign io_write  = r_active & (r_state == S_IO) & r_io_wr;
    assign mem_addr  = (r_state == S_FETCH) ? r_ip : r_maddr;
    assign mem_wdata = r_acc;
    assign io_wdata  = r_dr;
    assign halted    = (r_state == S_HALT);
    assign dbg_ip    = r_ip;

endmodule
`default_nettype wire

// File: tb/tb_sextium_core_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_sextium_core_p
// Description : Directed vector bench for sextium_core_p at WIDTH 16 and 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sextium_core_p;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance with wait-state memory and I/O models
    logic [15:0] a_mem_addr, a_mem_rdata, a_mem_wdata, a_io_wdata, a_dbg_ip;
    logic [15:0] a_io_rdata = 16'h1357;
    logic        a_mem_read, a_mem_write, a_io_read, a_io_write, a_halted;
    logic        a_mem_ready = 1'b0;
    logic        a_io_ready  = 1'b0;
    logic [15:0] mem [0:255];
    assign a_mem_rdata = mem[a_mem_addr[7:0]];

    sextium_core_p #(.WIDTH(16), .RESET_IP(16'h0000)) u_dut16 (
        .clock(clk), .reset(rst_n),
        .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata), .mem_wdata(a_mem_wdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_ready(a_mem_ready),
        .io_rdata(a_io_rdata), .io_wdata(a_io_wdata), .io_read(a_io_read),
        .io_write(a_io_write), .io_ready(a_io_ready), .halted(a_halted), .dbg_ip(a_dbg_ip)
    );

    // 32-bit instance with zero-wait buses
    logic [31:0] b_mem_addr, b_mem_rdata, b_mem_wdata, b_io_wdata, b_dbg_ip;
    logic [31:0] b_io_rdata = 32'h0;
    logic        b_mem_read, b_mem_write, b_io_read, b_io_write, b_halted;
    logic        b_ready = 1'b1;
    logic [31:0] mem32 [0:255];
    assign b_mem_rdata = mem32[b_mem_addr[7:0]];

    sextium_core_p #(.WIDTH(32), .RESET_IP(32'h0000_0010)) u_dut32 (
        .clock(clk), .reset(rst_n),
        .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata), .mem_wdata(b_mem_wdata),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_ready(b_ready),
        .io_rdata(b_io_rdata), .io_wdata(b_io_wdata), .io_read(b_io_read),
        .io_write(b_io_write), .io_ready(b_ready), .halted(b_halted), .dbg_ip(b_dbg_ip)
    );

    int mwait = 0;
    int iwait = 0;
    int mw_cnt = 0;
    int iw_cnt = 0;
    logic [15:0] st_addr = 16'h0;
    logic [15:0] st_data = 16'h0;
    logic [15:0] io_log  = 16'h0;

    always @(negedge clk) begin
        if (a_mem_read || a_mem_write) begin
            if (mw_cnt >= mwait) begin
                a_mem_ready = 1'b1;
                mw_cnt = 0;
                if (a_mem_write) begin
                    st_addr = a_mem_addr;
                    st_data = a_mem_wdata;
                end
            end else begin
                a_mem_ready = 1'b0;
                mw_cnt++;
            end
        end else begin
            a_mem_ready = 1'b0;
            mw_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (a_io_read || a_io_write) begin
            if (iw_cnt >= iwait) begin
                a_io_ready = 1'b1;
                iw_cnt = 0;
                if (a_io_write) io_log = a_io_wdata;
            end else begin
                a_io_ready = 1'b0;
                iw_cnt++;
            end
        end else begin
            a_io_ready = 1'b0;
            iw_cnt = 0;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc, rd, wr, ird, iwr, bad_total, hit_a, hit_b;
    logic [15:0] probe_a, probe_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 16'h0;
            mem32[i] = 32'h0;
        end
    endtask

    // Reset, release, then count strobe cycles until HALT or the cycle budget runs out.
    task automatic run16(input int w, input int iw);
        mwait = w;
        iwait = iw;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        cyc = 0; rd = 0; wr = 0; ird = 0; iwr = 0; hit_a = 0; hit_b = 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (a_mem_read)  rd++;
            if (a_mem_write) wr++;
            if (a_io_read)   ird++;
            if (a_io_write)  iwr++;
            if ((a_mem_read && a_mem_write) || (a_io_read && a_io_write) ||
                ((a_mem_read || a_mem_write) && (a_io_read || a_io_write))) bad_total++;
            if (a_mem_read && a_mem_addr == probe_a) hit_a++;
            if (a_mem_read && a_mem_addr == probe_b) hit_b++;
            if (a_halted) break;
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          w;
    } vec_t;
    vec_t vecs [16];

    initial begin
        // Program: CONST a; SWAPD; CONST b; op  ->  DR = b op a, reported via a final SWAPD
        vecs[0]  = '{4'hA, 16'h0005, 16'h0007, 16'h000C, 0};
        vecs[1]  = '{4'hA, 16'h0005, 16'h0007, 16'h000C, 3};
        vecs[2]  = '{4'hB, 16'h0005, 16'h0003, 16'hFFFE, 1};
        vecs[3]  = '{4'hC, 16'h0100, 16'h0123, 16'h2300, 0};
        vecs[4]  = '{4'hD, 16'h0007, 16'h0064, 16'h000E, 2};
        vecs[5]  = '{4'hD, 16'h0000, 16'h04D2, 16'hFFFF, 0};
        vecs[6]  = '{4'hE, 16'h0004, 16'h0001, 16'h0010, 0};
        vecs[7]  = '{4'hE, 16'hFFFC, 16'h8000, 16'h0800, 1};
        vecs[8]  = '{4'hE, 16'h0010, 16'h0001, 16'h0000, 0};
        vecs[9]  = '{4'hE, 16'hFFF0, 16'hFFFF, 16'h0000, 0};
        vecs[10] = '{4'hE, 16'h000F, 16'h0001, 16'h8000, 0};
        vecs[11] = '{4'hF, 16'hF0F0, 16'hFF00, 16'h0FFF, 0};
        vecs[12] = '{4'hA, 16'h0001, 16'hFFFF, 16'h0000, 0};
        vecs[13] = '{4'h0, 16'h0000, 16'h1234, 16'h1234, 0};
        vecs[14] = '{4'h6, 16'h0000, 16'h0005, 16'h0005, 0};
        vecs[15] = '{4'h5, 16'h0A0A, 16'h5050, 16'h0A0A, 2};
        bad_total = 0;
        probe_a = 16'hFFFF;
        probe_b = 16'hFFFF;

        // Reset state and first fetch
        clear_mem();
        mwait = 0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        check("rst_mem_read", a_mem_read, 1'b0);
        check("rst_halted", a_halted, 1'b0);
        check("rst_ip", a_dbg_ip, 16'h0000);
        check("rst_acc", a_mem_wdata, 16'h0000);
        check("rst_dr", a_io_wdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("c1_mem_read", a_mem_read, 1'b1);
        check("c1_mem_addr", a_mem_addr, 16'h0000);
        @(negedge clk);
        check("c2_ip", a_dbg_ip, 16'h0001);
        check("c2_mem_read", a_mem_read, 1'b0);
        repeat (4) @(negedge clk);
        check("c6_mem_read", a_mem_read, 1'b1);
        check("c6_mem_addr", a_mem_addr, 16'h0001);

        foreach (vecs[k]) begin
            clear_mem();
            mem[0] = {4'h9, 4'h5, 4'h9, vecs[k].op};
            mem[1] = vecs[k].a;
            mem[2] = vecs[k].b;
            mem[3] = 16'h5910;
            mem[4] = 16'h0000;
            run16(vecs[k].w, 0);
            check($sformatf("v%0d_halted", k), a_halted, 1'b1);
            check($sformatf("v%0d_result", k), a_io_wdata, vecs[k].exp);
            check($sformatf("v%0d_ip", k), a_dbg_ip, 16'h0005);
            check($sformatf("v%0d_acc", k), a_mem_wdata, 16'h0000);
            check($sformatf("v%0d_cycles", k), cyc, 13 + 5 * vecs[k].w);
            check($sformatf("v%0d_read_cycles", k), rd, 5 * (vecs[k].w + 1));
        end

        // Branch taken from slot 1: slots 2-3 would read address 3
        clear_mem();
        mem[0] = 16'h9400; mem[1] = 16'h0040; mem[2] = 16'h0699; mem[16'h40] = 16'h1000;
        probe_a = 16'h0003; probe_b = 16'h0040;
        run16(0, 0);
        check("bz_taken_halted", a_halted, 1'b1);
        check("bz_taken_ip", a_dbg_ip, 16'h0041);
        check("bz_taken_skip", hit_a, 0);
        check("bz_taken_target", hit_b, 1);

        // Branch not taken with ACC=1
        clear_mem();
        mem[0] = 16'h9490; mem[1] = 16'h0040; mem[2] = 16'h0001; mem[3] = 16'h0650; mem[4] = 16'h1000;
        run16(0, 0);
        check("bz_fall_halted", a_halted, 1'b1);
        check("bz_fall_ip", a_dbg_ip, 16'h0005);
        check("bz_fall_dr", a_io_wdata, 16'h0001);
        check("bz_fall_target", hit_b, 0);
        probe_a = 16'hFFFF; probe_b = 16'hFFFF;

        // STORE then LOAD through AR with one wait state
        clear_mem();
        mem[0] = 16'h9493; mem[1] = 16'h0080; mem[2] = 16'h5A5A; mem[3] = 16'h9259;
        mem[4] = 16'h1111; mem[5] = 16'h0000; mem[6] = 16'h1000; mem[16'h80] = 16'h3C3C;
        run16(1, 0);
        check("st_halted", a_halted, 1'b1);
        check("st_addr", st_addr, 16'h0080);
        check("st_data", st_data, 16'h5A5A);
        check("st_write_cycles", wr, 2);
        check("ld_dr", a_io_wdata, 16'h3C3C);
        check("ld_ip", a_dbg_ip, 16'h0007);

        // SYSCALL output, input, then halt; I/O ready after 2 wait cycles
        clear_mem();
        mem[0] = 16'h9591; mem[1] = 16'hBEEF; mem[2] = 16'h0002; mem[3] = 16'h9150;
        mem[4] = 16'h0001; mem[5] = 16'h9100; mem[6] = 16'h0000;
        run16(0, 2);
        check("io_halted", a_halted, 1'b1);
        check("io_wdata_at_write", io_log, 16'hBEEF);
        check("io_write_cycles", iwr, 3);
        check("io_read_cycles", ird, 3);
        check("io_in_dr", a_io_wdata, 16'h1357);
        check("io_ip", a_dbg_ip, 16'h0007);
        begin
            int strobes = 0;
            repeat (20) begin
                @(negedge clk);
                if (a_mem_read || a_mem_write || a_io_read || a_io_write || !a_halted) strobes++;
            end
            check("halt_quiet", strobes, 0);
            check("halt_ip_frozen", a_dbg_ip, 16'h0007);
        end
        check("bus_exclusive", bad_total, 0);

        // WIDTH=32: eight slots per word, signed SHIFT right, DIV by zero
        clear_mem();
        mem32[16'h10] = 32'h959E_595D; mem32[16'h11] = 32'hFFFF_FFFC;
        mem32[16'h12] = 32'h8000_0000; mem32[16'h13] = 32'h0000_0000;
        mem32[16'h14] = 32'h5910_0000; mem32[16'h15] = 32'h0000_0000;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("w32_c1_mem_read", b_mem_read, 1'b1);
        check("w32_c1_addr", b_mem_addr, 32'h0000_0010);
        repeat (7) @(negedge clk);
        check("w32_shift_acc", b_mem_wdata, 32'h0800_0000);
        @(negedge clk);
        check("w32_shift_dr", b_io_wdata, 32'h0800_0000);
        repeat (4) @(negedge clk);
        check("w32_refetch_read", b_mem_read, 1'b1);
        check("w32_refetch_addr", b_mem_addr, 32'h0000_0014);
        @(negedge clk);
        check("w32_div0_acc", b_mem_wdata, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        check("w32_halted", b_halted, 1'b1);
        check("w32_dr", b_io_wdata, 32'hFFFF_FFFF);
        check("w32_ip", b_dbg_ip, 32'h0000_0016);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
